// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep checker: FSM encoding, counter widths
// and the saturating error increment.
package gate_sweep_pkg;

    localparam int ERR_W   = 8;
    localparam int DWELL_W = 8;
    localparam int SWEEP_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/sweep_dwell_timer.sv
// Dwell timer: counts cycles while clear is low and flags the last APPLY cycle,
// so that APPLY plus the following SAMPLE cycle spans exactly DWELL cycles.
module sweep_dwell_timer
    import gate_sweep_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expire
);

    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 2);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + DWELL_W'(1);
        if (clear) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge value of its neighbours; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = !clear && (cnt_q == LAST);

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table checker: sweeps every input vector of a small gate,
// samples its output once per vector and counts mismatches against exp_tt.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int DWELL  = 4,
    parameter int SWEEPS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2**N_IN-1:0]    exp_tt,
    input  logic                  dut_out,
    output logic [N_IN-1:0]       vec,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [2**N_IN-1:0]    tt_cap
);

    localparam logic [SWEEP_W-1:0] LAST_SWEEP = SWEEP_W'(SWEEPS - 1);

    state_e               state_q, state_d;
    logic [N_IN-1:0]      vec_q, vec_d;
    logic [SWEEP_W-1:0]   sweep_q, sweep_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [2**N_IN-1:0]   tt_q, tt_d;
    logic                 dwell_clear;
    logic                 dwell_expire;

    // The timer free-runs only in APPLY, so it is already zero on every entry.
    assign dwell_clear = (state_q != APPLY);

    sweep_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (dwell_clear),
        .expire (dwell_expire)
    );

    // NOTE: every next-state value is given its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        sweep_d = sweep_q;
        err_d   = err_q;
        tt_d    = tt_q;

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            vec_d   = '0;
            sweep_d = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start && !abort) begin
                        state_d = APPLY;
                        vec_d   = '0;
                        sweep_d = '0;
                        err_d   = '0;
                        tt_d    = '0;
                    end
                end
                APPLY: begin
                    if (dwell_expire) begin
                        state_d = SAMPLE;
                    end
                end
                SAMPLE: begin
                    // exp_tt is read live here, never latched at start.
                    tt_d[vec_q] = dut_out;
                    if (dut_out != exp_tt[vec_q]) begin
                        err_d = sat_inc(err_q);
                    end
                    if (vec_q == '1) begin
                        vec_d = '0;
                        if (sweep_q < LAST_SWEEP) begin
                            sweep_d = sweep_q + SWEEP_W'(1);
                            state_d = APPLY;
                        end else begin
                            sweep_d = '0;
                            state_d = DONE;
                        end
                    end else begin
                        vec_d   = vec_q + N_IN'(1);
                        state_d = APPLY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: tt_cap is a plain register rather than a RAM, so it is cheap to
    // clear on reset and the captured table never shows stale bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            sweep_q <= '0;
            err_q   <= '0;
            tt_q    <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            sweep_q <= sweep_d;
            err_q   <= err_d;
            tt_q    <= tt_d;
        end
    end

    assign vec       = vec_q;
    assign busy      = (state_q == APPLY) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = (state_q == DONE) && (err_q == '0);
    assign err_count = err_q;
    assign tt_cap    = tt_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench for gate_sweep_checker: three parameterisations, a vector
// table, hand-written abort/reset/restart sequences and a randomized model check.
module tb_gate_sweep_checker;

    localparam int TIMEOUT = 5000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 2: N_IN=2, DWELL=4, SWEEPS=1
    logic start2 = 1'b0, abort2 = 1'b0;
    logic [3:0] exp2 = 4'b0111, gate2 = 4'b0111;
    logic [1:0] vec2;
    logic busy2, done2, pass2;
    logic [7:0] err2;
    logic [3:0] cap2;

    // Instance 3: N_IN=3, DWELL=4, SWEEPS=3
    logic start3 = 1'b0, abort3 = 1'b0;
    logic [7:0] exp3 = 8'hFF, gate3 = 8'h00;
    logic [2:0] vec3;
    logic busy3, done3, pass3;
    logic [7:0] err3;
    logic [7:0] cap3;

    // Instance 8: N_IN=8, DWELL=2, SWEEPS=2
    logic start8 = 1'b0, abort8 = 1'b0;
    logic [255:0] exp8 = '1, gate8 = '0;
    logic [7:0] vec8;
    logic busy8, done8, pass8;
    logic [7:0] err8;
    logic [255:0] cap8;

    gate_sweep_checker #(.N_IN(2), .DWELL(4), .SWEEPS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .exp_tt(exp2),
        .dut_out(gate2[vec2]), .vec(vec2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .tt_cap(cap2));

    gate_sweep_checker #(.N_IN(3), .DWELL(4), .SWEEPS(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .exp_tt(exp3),
        .dut_out(gate3[vec3]), .vec(vec3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .tt_cap(cap3));

    gate_sweep_checker #(.N_IN(8), .DWELL(2), .SWEEPS(2)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8), .exp_tt(exp8),
        .dut_out(gate8[vec8]), .vec(vec8), .busy(busy8), .done(done8), .pass(pass8),
        .err_count(err8), .tt_cap(cap8));

    typedef struct {
        logic [3:0] exp_tt;
        logic [3:0] gate_tt;
        logic [7:0] err;
        logic [3:0] cap;
        logic       pass;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int dwell_of(input int sel);
        return (sel == 2) ? 4 : (sel == 3) ? 4 : 2;
    endfunction

    function automatic int nvec_of(input int sel);
        return (sel == 2) ? 4 : (sel == 3) ? 8 : 256;
    endfunction

    function automatic int vec_of(input int sel);
        return (sel == 2) ? int'(vec2) : (sel == 3) ? int'(vec3) : int'(vec8);
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 2) ? done2 : (sel == 3) ? done3 : done8;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 2) ? busy2 : (sel == 3) ? busy3 : busy8;
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            2:       start2 = v;
            3:       start3 = v;
            default: start8 = v;
        endcase
    endtask

    // Returns at the negedge inside the first cycle after start was sampled.
    task automatic pulse_start(input int sel);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
    endtask

    // Counts cycles until done, checking the vector walk and busy along the way.
    task automatic wait_done(input int sel, input int exp_cycles, input string name, input bit busy_starts);
        int cycles = 0;
        int bad_vec = 0;
        int bad_busy = 0;
        int dw = dwell_of(sel);
        int nv = nvec_of(sel);
        while (!done_of(sel) && cycles < TIMEOUT) begin
            if (vec_of(sel) != (cycles / dw) % nv) bad_vec++;
            if (!busy_of(sel)) bad_busy++;
            if (busy_starts && (cycles == 3 || cycles == 9)) set_start(sel, 1'b1);
            @(negedge clk);
            set_start(sel, 1'b0);
            cycles++;
        end
        check({name, "_cycles"}, cycles, exp_cycles);
        check({name, "_vec_seq"}, bad_vec, 0);
        check({name, "_busy"}, bad_busy, 0);
    endtask

    // Reference: each mismatching truth-table entry costs one error per sweep.
    function automatic int model_err(input logic [255:0] e, input logic [255:0] g, input int sweeps);
        int n = $countones(e ^ g) * sweeps;
        return (n > 255) ? 255 : n;
    endfunction

    initial begin
        tbl[0] = '{exp_tt: 4'b0111, gate_tt: 4'b0111, err: 8'd0, cap: 4'b0111, pass: 1'b1}; // NAND
        tbl[1] = '{exp_tt: 4'b0111, gate_tt: 4'b1111, err: 8'd1, cap: 4'b1111, pass: 1'b0}; // stuck-1
        tbl[2] = '{exp_tt: 4'b0111, gate_tt: 4'b0000, err: 8'd3, cap: 4'b0000, pass: 1'b0}; // stuck-0
        tbl[3] = '{exp_tt: 4'b0111, gate_tt: 4'b1000, err: 8'd4, cap: 4'b1000, pass: 1'b0}; // AND
        tbl[4] = '{exp_tt: 4'b0110, gate_tt: 4'b0110, err: 8'd0, cap: 4'b0110, pass: 1'b1}; // XOR
        tbl[5] = '{exp_tt: 4'b1110, gate_tt: 4'b0110, err: 8'd1, cap: 4'b0110, pass: 1'b0}; // XOR vs OR

        // Reset state
        #1;
        check("rst_vec", vec2, 0);
        check("rst_busy", busy2, 0);
        check("rst_done", done2, 0);
        check("rst_pass", pass2, 0);
        check("rst_err", err2, 0);
        check("rst_cap", cap2, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy2, 0);

        // Vector table on the 2-input instance
        for (int i = 0; i < 6; i++) begin
            exp2 = tbl[i].exp_tt;
            gate2 = tbl[i].gate_tt;
            pulse_start(2);
            wait_done(2, 16, $sformatf("tbl%0d", i), 1'b0);
            check($sformatf("tbl%0d_err", i), err2, tbl[i].err);
            check($sformatf("tbl%0d_cap", i), cap2, tbl[i].cap);
            check($sformatf("tbl%0d_pass", i), pass2, tbl[i].pass);
            check($sformatf("tbl%0d_done", i), done2, 1);
        end

        // DONE holds vec=0 and results until the next start
        repeat (5) @(negedge clk);
        check("done_hold_vec", vec2, 0);
        check("done_hold_done", done2, 1);
        check("done_hold_err", err2, 1);

        // exp_tt is read live during the run
        exp2 = 4'b0111;
        gate2 = 4'b0111;
        pulse_start(2);
        exp2 = 4'b1111;
        wait_done(2, 16, "live_exp", 1'b0);
        check("live_exp_err", err2, 1);
        check("live_exp_cap", cap2, 4'b0111);

        // start pulses while busy leave timing unchanged
        exp2 = 4'b0111;
        gate2 = 4'b0111;
        pulse_start(2);
        wait_done(2, 16, "busy_start", 1'b1);
        check("busy_start_pass", pass2, 1);

        // start in DONE restarts with cleared counts
        gate2 = 4'b1111;
        pulse_start(2);
        wait_done(2, 16, "pre_restart", 1'b0);
        check("pre_restart_err", err2, 1);
        gate2 = 4'b0111;
        pulse_start(2);
        check("restart_err_clear", err2, 0);
        check("restart_busy", busy2, 1);
        check("restart_done_low", done2, 0);
        wait_done(2, 16, "restart", 1'b0);
        check("restart_pass", pass2, 1);

        // abort at cycle 6 with a simultaneous start
        gate2 = 4'b0000;
        pulse_start(2);
        repeat (5) @(negedge clk);
        abort2 = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        start2 = 1'b0;
        check("abort_busy", busy2, 0);
        check("abort_done", done2, 0);
        check("abort_pass", pass2, 0);
        check("abort_vec", vec2, 0);
        check("abort_err_kept", err2, 1);
        repeat (3) @(negedge clk);
        check("abort_start_ignored", busy2, 0);

        // asynchronous reset mid-run
        gate2 = 4'b1111;
        pulse_start(2);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vec", vec2, 0);
        check("arst_busy", busy2, 0);
        check("arst_done", done2, 0);
        check("arst_err", err2, 0);
        check("arst_cap", cap2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_stay_idle", busy2, 0);
        gate2 = 4'b0111;
        pulse_start(2);
        wait_done(2, 16, "post_rst", 1'b0);
        check("post_rst_pass", pass2, 1);
        check("post_rst_cap", cap2, 4'b0111);

        // 3-input, three sweeps, stuck-at-0
        pulse_start(3);
        wait_done(3, 96, "n3", 1'b0);
        check("n3_err", err3, 24);
        check("n3_pass", pass3, 0);
        check("n3_cap", cap3, 0);

        // 8-input, two sweeps, stuck-at-0: saturation
        pulse_start(8);
        wait_done(8, 1024, "n8", 1'b0);
        check("n8_err_sat", err8, 255);
        check("n8_pass", pass8, 0);
        check("n8_cap", cap8, 0);

        // Randomized truth tables against the counting model
        for (int i = 0; i < 12; i++) begin
            exp2 = 4'($urandom);
            gate2 = 4'($urandom);
            pulse_start(2);
            wait_done(2, 16, $sformatf("rnd2_%0d", i), 1'($urandom));
            check($sformatf("rnd2_%0d_err", i), err2, model_err(256'(exp2), 256'(gate2), 1));
            check($sformatf("rnd2_%0d_cap", i), cap2, gate2);
            check($sformatf("rnd2_%0d_pass", i), pass2, model_err(256'(exp2), 256'(gate2), 1) == 0);
        end
        for (int i = 0; i < 6; i++) begin
            exp3 = 8'($urandom);
            gate3 = (i == 0) ? exp3 : 8'($urandom);
            pulse_start(3);
            wait_done(3, 96, $sformatf("rnd3_%0d", i), 1'b0);
            check($sformatf("rnd3_%0d_err", i), err3, model_err(256'(exp3), 256'(gate3), 3));
            check($sformatf("rnd3_%0d_cap", i), cap3, gate3);
            check($sformatf("rnd3_%0d_pass", i), pass3, model_err(256'(exp3), 256'(gate3), 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 SHALL have parameter N_IN, default 2, number of gate inputs driven; legal range 1..8.
REQ-002 SHALL have parameter DWELL, default 4, clock cycles each vector is held; legal range 2..255.
REQ-003 SHALL have parameter SWEEPS, default 1, full passes over all 2^N_IN vectors per run; legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that begins a run; honoured only in IDLE or DONE.
REQ-007 SHALL have port abort, input, 1 bit: ends a run in progress and returns to IDLE.
REQ-008 SHALL have port exp_tt, input, 2^N_IN bits: expected truth table; bit k is the expected output for vector k.
REQ-009 SHALL have port dut_out, input, 1 bit: output of the gate under test.
REQ-010 SHALL have port vec, output, N_IN bits: stimulus vector to the gate; bit 0 toggles fastest.
REQ-011 SHALL have port busy, output, 1 bit: high in APPLY and SAMPLE.
REQ-012 SHALL have port done, output, 1 bit: high in DONE.
REQ-013 SHALL have port pass, output, 1 bit: high in DONE when err_count is 0.
REQ-014 SHALL have port err_count, output, 8 bits: count of mismatches, saturating at 255.
REQ-015 SHALL have port tt_cap, output, 2^N_IN bits: captured truth table from the most recent sweep.

Function
REQ-016 SHALL implement FSM states IDLE, APPLY, SAMPLE, DONE.
REQ-017 IDLE->APPLY on start: vec=0, sweep index=0, dwell counter=0, err_count=0, tt_cap=0.
REQ-018 APPLY SHALL hold vec for DWELL-1 cycles, then go to SAMPLE.
REQ-019 SAMPLE lasts one cycle: register dut_out into tt_cap[vec]; if dut_out != exp_tt[vec], increment err_count with saturation.
REQ-020 SAMPLE with vec < 2^N_IN-1: vec+1, dwell counter=0, go to APPLY; each vector occupies exactly DWELL cycles.
REQ-021 SAMPLE with vec = 2^N_IN-1: vec wraps to 0; if sweep index < SWEEPS-1, increment sweep index and go to APPLY, else go to DONE.
REQ-022 A run SHALL last exactly SWEEPS*2^N_IN*DWELL cycles from the cycle after start to the first DONE cycle.
REQ-023 DONE SHALL hold vec=0 and keep err_count and tt_cap until the next start; start in DONE behaves as in REQ-017.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort in any state other than IDLE: go to IDLE next cycle with vec=0, err_count and tt_cap kept, done=0, pass=0; abort takes priority over start and sample in the same cycle.
REQ-026 pass SHALL be combinational from state==DONE and err_count==0; never high outside DONE.
REQ-027 exp_tt SHALL be sampled live at each SAMPLE cycle and is not latched at start.

Reset
REQ-028 rst_n low SHALL force, without waiting for clk: state=IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, tt_cap=0, all counters=0.
REQ-029 Reset asserted mid-run SHALL discard the run; after release the block sits in IDLE until start.

Structure
REQ-030 A shared package gate_sweep_pkg SHALL hold the state encoding (IDLE=0, APPLY=1, SAMPLE=2, DONE=3) and the err_count width constant ERR_W=8.
REQ-031 The dwell timer SHALL be a sub-module sweep_dwell_timer (clk, rst_n, clear, expire) parametrised by DWELL.
REQ-032 The module SHALL be synthesizable RTL, with no delays or switch primitives.

Verification
REQ-033 Bench with N_IN=2, DWELL=4, SWEEPS=1, ideal NAND DUT, exp_tt=4'b0111, start pulse: vec sequence 0,1,2,3 at 4 cycles each; done after 16 cycles; pass=1; err_count=0; tt_cap=4'b0111.
REQ-034 Same setup, DUT stuck-at-1 and exp_tt=4'b0111: err_count=1, pass=0, tt_cap=4'b1111.
REQ-035 N_IN=3, SWEEPS=3, DUT stuck-at-0, exp_tt=8'hFF: done after 96 cycles with err_count=24; with N_IN=8, SWEEPS=2 under the same fault, err_count saturates at 255.
REQ-036 abort at cycle 6 of a run: IDLE next cycle, vec=0, done=0, err_count kept; a start issued in the same cycle as the abort is ignored.
REQ-037 rst_n pulled low between clock edges mid-run: all outputs reach their reset values immediately; a subsequent start runs a clean full sweep.
REQ-038 start pulses while busy, and start in DONE: the busy pulses leave timing unchanged; the DONE start restarts with err_count cleared.
